fifo_enq_arbiter: RTL and testbench
===================================

// Module: fifo_enq_arbiter
// PURPOSE
//   Round-robin arbiter sharing one fifo enqueue port among N_REQ requesters.
//   Sits between producer pipelines (e.g. dispatch lanes, writeback sources) and a
//   single fifo instance. Drives its valid_enq/data_enq and consumes its ready_enq.
//   A grant is held stable until the fifo accepts it; priority rotates after each transfer.
// PARAMETERS
//   N_REQ       4   number of requesters (>=2); IDX_WIDTH = $clog2(N_REQ)
//   DATA_WIDTH  32  payload width, must match the downstream fifo
// PORTS
//   clk        in   1               clock, all state updates on posedge
//   rst        in   1               synchronous reset, active-high
//   req_valid  in   N_REQ           per-requester valid
//   req_ready  out  N_REQ           per-requester ready (one-hot or zero)
//   req_data   in   N_REQ*DATA_WIDTH  requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_enq  out  1               to fifo: selected requester has data
//   ready_enq  in   1               from fifo: not full
//   data_enq   out  DATA_WIDTH      to fifo: selected payload
//   grant_idx  out  IDX_WIDTH       index of the currently selected requester (0 when none)
// BEHAVIOUR
// - State: rr_ptr[IDX_WIDTH] (highest-priority index), lock (1b), lock_idx[IDX_WIDTH].
// - Reset (rst=1 at posedge): rr_ptr=0, lock=0, lock_idx=0. While rst=1, valid_enq=0,
//   req_ready=0, grant_idx=0, data_enq=0 (forced; outputs are combinational otherwise).
// - FSM: ARB (lock=0) / HOLD (lock=1).
//   ARB: sel = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   HOLD: sel = lock_idx, no re-arbitration.
// - valid_enq = req_valid[sel] (0 if no requester valid); data_enq = req_data[sel];
//   grant_idx = sel; req_ready[sel] = ready_enq & valid_enq; all other req_ready = 0.
// - Transfer = valid_enq & ready_enq. Zero-latency: combinational path, data reaches
//   fifo the same cycle; one transfer max per cycle.
// - Transitions at posedge:
//   ARB, transfer                      -> ARB, rr_ptr = sel+1 (wrap N_REQ-1 -> 0)
//   ARB, valid_enq & !ready_enq        -> HOLD, lock_idx = sel, rr_ptr unchanged
//   ARB, no valid                      -> ARB, no change
//   HOLD, transfer                     -> ARB, rr_ptr = lock_idx+1 (wrap)
//   HOLD, !ready_enq & req_valid[lock_idx] -> HOLD
//   HOLD, req_valid[lock_idx]=0 (protocol violation) -> ARB, rr_ptr unchanged; valid_enq
//     is 0 that cycle (no re-arbitration within the same cycle)
// - Requester rule: once req_valid[i]=1 it holds valid and data until req_ready[i]=1.
// - Full fifo (ready_enq=0) indefinitely: grant frozen, no starvation reshuffle.
// - Fairness: with all N_REQ valid and ready_enq=1, each requester wins exactly once
//   every N_REQ cycles.
// - Non-power-of-2 N_REQ: rr_ptr wraps at N_REQ-1, never takes values >= N_REQ.
// - Reset mid-HOLD: lock dropped, next cycle arbitrates from index 0.
// CONFIGURATION
// - FIFO_ARB_GRANT_CNT_EN defined: adds output grant_cnt [N_REQ*16], one 16-bit
//   counter per requester at [i*16 +: 16], +1 on each transfer from requester i,
//   saturating at 16'hFFFF, cleared by rst. Not defined: port and counters absent;
//   all other behaviour identical.
// TESTING
// 1. rst=1 2 cycles, all req_valid=1 -> valid_enq=0, req_ready=0; after release
//    grant_idx=0 first cycle.
// 2. N_REQ=4, all valid, ready_enq=1 for 8 cycles -> grant_idx 0,1,2,3,0,1,2,3;
//    data_enq matches req_data slice each cycle.
// 3. Only req 2 valid (data 32'hA5A5_0002), ready_enq=0 for 3 cycles then 1 -> valid_enq=1
//    and grant_idx=2 all 4 cycles; req 0 raised in cycle 2 is not granted; transfer in
//    cycle 4, next grant is req 0 (rr_ptr=3 wraps to 0).
// 4. HOLD on req 1, req 1 drops valid -> valid_enq=0 that cycle, next cycle ARB from rr_ptr.
// 5. N_REQ=3, all valid, ready_enq=1 -> grant_idx 0,1,2,0; rr_ptr never equals 3.
// 6. FIFO_ARB_GRANT_CNT_EN: req 0 alone 70000 transfers -> grant_cnt[15:0]=16'hFFFF,
//    other counters 0; rst clears all to 0.

Source files
------------

// File: rtl/fifo_enq_arbiter.sv
// rtl/fifo_enq_arbiter.sv - round-robin arbiter sharing one fifo enqueue port among N_REQ requesters
// Optional per-requester saturating grant counters enabled by defining FIFO_ARB_GRANT_CNT_EN.
module fifo_enq_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic                          valid_enq,
  input  logic                          ready_enq,
  output logic [DATA_WIDTH-1:0]         data_enq,
  output logic [$clog2(N_REQ)-1:0]      grant_idx
`ifdef FIFO_ARB_GRANT_CNT_EN
  ,
  output logic [N_REQ*16-1:0]           grant_cnt
`endif
);

  localparam int IDX_WIDTH = $clog2(N_REQ);
  localparam logic [IDX_WIDTH:0]   N_REQ_W = (IDX_WIDTH+1)'(N_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_REQ - 1);

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state, next_state;
  logic [IDX_WIDTH-1:0]   rr_ptr, next_rr_ptr;
  logic [IDX_WIDTH-1:0]   lock_idx, next_lock_idx;

  logic [DATA_WIDTH-1:0]  data_arr [N_REQ];
  logic [IDX_WIDTH:0]     sum;
  logic [IDX_WIDTH-1:0]   cand;
  logic [IDX_WIDTH-1:0]   arb_sel;
  logic                   arb_found;
  logic [IDX_WIDTH-1:0]   sel;
  logic                   sel_valid;
  logic                   transfer;

  function automatic logic [IDX_WIDTH-1:0] inc_wrap(input logic [IDX_WIDTH-1:0] i);
    return (i == LAST_IDX) ? '0 : IDX_WIDTH'(i + 1'b1);
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotating priority search; one conditional subtract is enough since rr_ptr and k are both < N_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_WIDTH+1)'(k);
      if (sum >= N_REQ_W) begin
        sum = sum - N_REQ_W;
      end
      cand = sum[IDX_WIDTH-1:0];
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
  end

  always_comb begin
    next_state    = state;
    next_rr_ptr   = rr_ptr;
    next_lock_idx = lock_idx;
    sel           = '0;
    sel_valid     = 1'b0;
    case (state)
      ARB: begin
        if (arb_found) begin
          sel       = arb_sel;
          sel_valid = 1'b1;
          if (ready_enq) begin
            next_rr_ptr = inc_wrap(arb_sel);
          end else begin
            next_state    = HOLD;
            next_lock_idx = arb_sel;
          end
        end
      end
      HOLD: begin
        // A requester withdrawing while locked just releases the lock; no same-cycle re-arbitration.
        if (req_valid[lock_idx]) begin
          sel       = lock_idx;
          sel_valid = 1'b1;
          if (ready_enq) begin
            next_state  = ARB;
            next_rr_ptr = inc_wrap(lock_idx);
          end
        end else begin
          next_state = ARB;
        end
      end
      default: next_state = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= next_state;
      rr_ptr   <= next_rr_ptr;
      lock_idx <= next_lock_idx;
    end
  end

  always_comb begin
    valid_enq = sel_valid & ~rst;
    transfer  = valid_enq & ready_enq;
    grant_idx = rst ? '0 : sel;
    data_enq  = rst ? '0 : data_arr[sel];
    req_ready = '0;
    if (transfer) begin
      req_ready[sel] = 1'b1;
    end
  end

`ifdef FIFO_ARB_GRANT_CNT_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (req_ready[i] && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign grant_cnt[i*16 +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb/tb_fifo_enq_arbiter.sv - scoreboard bench for fifo_enq_arbiter (N_REQ=4 and N_REQ=3 instances)
module tb_fifo_enq_arbiter;

  typedef struct {
    int          cyc;
    bit          dut3;
    logic        v;
    int          idx;
    logic [31:0] data;
    logic [3:0]  rdy;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           cyc = 0;

  logic [3:0]   rv4 = '0;
  logic [3:0]   rr4;
  logic [127:0] rd4 = '0;
  logic         ve4;
  logic         re4 = 1'b0;
  logic [31:0]  de4;
  logic [1:0]   gi4;

  logic [2:0]   rv3 = '0;
  logic [2:0]   rr3;
  logic [95:0]  rd3 = '0;
  logic         ve3;
  logic         re3 = 1'b0;
  logic [31:0]  de3;
  logic [1:0]   gi3;

`ifdef FIFO_ARB_GRANT_CNT_EN
  logic [63:0]  gc4;
  logic [47:0]  gc3;
`endif

  exp_t exp_q[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;

  fifo_enq_arbiter #(.N_REQ(4), .DATA_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rr4), .req_data(rd4),
    .valid_enq(ve4), .ready_enq(re4), .data_enq(de4), .grant_idx(gi4)
`ifdef FIFO_ARB_GRANT_CNT_EN
    , .grant_cnt(gc4)
`endif
  );

  fifo_enq_arbiter #(.N_REQ(3), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3), .req_data(rd3),
    .valid_enq(ve3), .ready_enq(re3), .data_enq(de3), .grant_idx(gi3)
`ifdef FIFO_ARB_GRANT_CNT_EN
    , .grant_cnt(gc3)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due this cycle and compares it against the addressed instance.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      logic        av;
      int          aidx;
      logic [31:0] ad;
      logic [3:0]  ardy;
      bit          ok;
      e = exp_q.pop_front();
      if (e.dut3) begin
        av = ve3; aidx = int'(gi3); ad = de3; ardy = {1'b0, rr3};
      end else begin
        av = ve4; aidx = int'(gi4); ad = de4; ardy = rr4;
      end
      ok = (e.cyc == cyc) && (av === e.v) && (e.idx < 0 || aidx == e.idx)
           && (!e.v || ad === e.data) && (ardy === e.rdy);
      n_total++;
      if (ok) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc %0d (due %0d): got v=%0b idx=%0d data=%h rdy=%b, want v=%0b idx=%0d data=%h rdy=%b",
                 e.dut3 ? "dut3" : "dut4", cyc, e.cyc, av, aidx, ad, ardy, e.v, e.idx, e.data, e.rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic e4(input logic v, input int idx, input logic [31:0] d, input logic [3:0] r);
    exp_t x;
    x.cyc = cyc; x.dut3 = 1'b0; x.v = v; x.idx = idx; x.data = d; x.rdy = r;
    exp_q.push_back(x);
  endtask

  task automatic e3(input logic v, input int idx, input logic [31:0] d, input logic [2:0] r);
    exp_t x;
    x.cyc = cyc; x.dut3 = 1'b1; x.v = v; x.idx = idx; x.data = d; x.rdy = {1'b0, r};
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, want);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rd4[i*32 +: 32] = 32'hD400_0000 + 32'(i);
    for (int i = 0; i < 3; i++) rd3[i*32 +: 32] = 32'hD300_0000 + 32'(i);

    // Reset with every requester asserting valid: outputs forced quiet.
    for (int k = 0; k < 2; k++) begin
      tick(); rst = 1'b1; rv4 = 4'hF; re4 = 1'b1; rv3 = 3'h7; re3 = 1'b1;
      e4(1'b0, 0, 32'h0, 4'b0000);
      e3(1'b0, 0, 32'h0, 3'b000);
    end

    // All four valid, fifo always ready: strict rotation starting at 0.
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin rst = 1'b0; rv3 = 3'b000; end
      e4(1'b1, k % 4, 32'hD400_0000 + 32'(k % 4), 4'(1 << (k % 4)));
    end

    // Lone req 2 against a full fifo: grant frozen, late req 0 ignored, then wrap to 0.
    tick(); rv4 = 4'b0100; rd4[64 +: 32] = 32'hA5A5_0002; re4 = 1'b0;
    e4(1'b1, 2, 32'hA5A5_0002, 4'b0000);
    tick(); rv4 = 4'b0101; rd4[0 +: 32] = 32'h0000_00A0;
    e4(1'b1, 2, 32'hA5A5_0002, 4'b0000);
    tick();
    e4(1'b1, 2, 32'hA5A5_0002, 4'b0000);
    tick(); re4 = 1'b1;
    e4(1'b1, 2, 32'hA5A5_0002, 4'b0100);
    tick(); rv4 = 4'b0001;
    e4(1'b1, 0, 32'h0000_00A0, 4'b0001);
    tick(); rv4 = 4'b0000;
    e4(1'b0, 0, 32'h0, 4'b0000);

    // Locked req 1 withdraws: quiet cycle, then arbitration resumes from rr_ptr=1 (picks 3 over 0).
    tick(); rv4 = 4'b0010; rd4[32 +: 32] = 32'h0000_00B1; re4 = 1'b0;
    e4(1'b1, 1, 32'h0000_00B1, 4'b0000);
    tick(); rv4 = 4'b1001; rd4[96 +: 32] = 32'h0000_00B3; rd4[0 +: 32] = 32'h0000_00B0;
    e4(1'b0, -1, 32'h0, 4'b0000);
    tick(); re4 = 1'b1;
    e4(1'b1, 3, 32'h0000_00B3, 4'b1000);
    tick(); rv4 = 4'b0001;
    e4(1'b1, 0, 32'h0000_00B0, 4'b0001);
    tick(); rv4 = 4'b0000;
    e4(1'b0, 0, 32'h0, 4'b0000);

    // Reset while holding req 3: lock dropped, arbitration restarts from index 0.
    tick(); rv4 = 4'b1000; rd4[96 +: 32] = 32'h0000_00C3; re4 = 1'b0;
    e4(1'b1, 3, 32'h0000_00C3, 4'b0000);
    tick(); rst = 1'b1;
    e4(1'b0, 0, 32'h0, 4'b0000);
    tick(); rst = 1'b0; rv4 = 4'b1011; re4 = 1'b1;
    rd4[0 +: 32] = 32'h0000_00C0; rd4[32 +: 32] = 32'h0000_00C1;
    e4(1'b1, 0, 32'h0000_00C0, 4'b0001);
    tick(); rv4 = 4'b1010;
    e4(1'b1, 1, 32'h0000_00C1, 4'b0010);
    tick(); rv4 = 4'b1000;
    e4(1'b1, 3, 32'h0000_00C3, 4'b1000);
    tick(); rv4 = 4'b0000;
    e4(1'b0, 0, 32'h0, 4'b0000);

    // Three requesters: rotation wraps 2 -> 0 without visiting index 3.
    tick(); rv3 = 3'b111; re3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      e3(1'b1, k % 3, 32'hD300_0000 + 32'(k % 3), 3'(1 << (k % 3)));
    end
    tick(); rv3 = 3'b001;
    e3(1'b1, 0, 32'hD300_0000, 3'b001);
    tick(); rv3 = 3'b000;
    e3(1'b0, 0, 32'h0, 3'b000);

`ifdef FIFO_ARB_GRANT_CNT_EN
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; rv4 = 4'b0001; re4 = 1'b1;
    for (int k = 0; k < 70000; k++) tick();
    rv4 = 4'b0000;
    tick();
    chk("grant_cnt0_sat", {48'h0, gc4[15:0]}, 64'h0000_0000_0000_FFFF);
    chk("grant_cnt_others", {16'h0, gc4[63:16]}, 64'h0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    chk("grant_cnt_rst", gc4, 64'h0);
`endif

    tick(); tick();
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
